// File: rtl/baudrate_gen.sv
// -----------------------------------------------------------------------------
// baudrate_gen
//
// Purpose:
//   Generates a one-clk-wide baud tick (rateclk) every DIV enabled clock
//   cycles, where DIV is one of two compile-time ratios chosen at run time by
//   sel. A change of sel restarts the period from zero so the new rate's first
//   tick lands a full DIV cycles after the switch. ce freezes the count
//   without losing progress.
//
// Parameters:
//   DIV0 - divide ratio used when sel=0 (>= 2)
//   DIV1 - divide ratio used when sel=1 (>= 2)
//
// Ports:
//   clk     - single clock, rising-edge active
//   rst     - asynchronous, active-high reset
//   sel     - rate select (0 -> DIV0, 1 -> DIV1)
//   ce      - count enable
//   rateclk - registered baud tick, high for exactly one clk cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module baudrate_gen #(
  parameter int DIV0 = 16,
  parameter int DIV1 = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic ce,
  output logic rateclk
);

  localparam int DIV_MAX = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int CW      = $clog2(DIV_MAX);

  // Terminal counts are precomputed so the compare is a plain equality and
  // the wrap goes to zero explicitly rather than relying on overflow.
  localparam logic [CW-1:0] TC0 = CW'(DIV0 - 1);
  localparam logic [CW-1:0] TC1 = CW'(DIV1 - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] tc;
  logic          sel_q;
  logic          rateclk_d;

  // Next-state logic. The active ratio follows sel_q, not sel, so the rate
  // in force during a period is the one the period was started with.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missed branch in always_comb would otherwise infer a latch.
    tc        = sel_q ? TC1 : TC0;
    cnt_d     = cnt;
    rateclk_d = 1'b0;

    if (sel != sel_q) begin
      // Rate change wins over ce: restart the new rate's period from zero.
      cnt_d = '0;
    end else if (ce) begin
      if (cnt == tc) begin
        cnt_d     = '0;
        rateclk_d = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  // State register. rateclk comes straight from a flop, so there is no
  // combinational path from any input to the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sel_q   <= 1'b0;
      rateclk <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here update from the
      // pre-edge values, matching real registers regardless of statement order.
      cnt     <= cnt_d;
      sel_q   <= sel;
      rateclk <= rateclk_d;
    end
  end

endmodule

// File: tb/tb_baudrate_gen.sv
// -----------------------------------------------------------------------------
// tb_baudrate_gen
//
// Self-checking bench for baudrate_gen (DIV0=16, DIV1=4, 2 ns clock).
// A behavioural reference model advances on every rising edge and pushes the
// expected rateclk/cnt onto scoreboard queues; each scenario task pops those
// entries after the edge and compares them with the DUT, and additionally
// checks the absolute tick positions that the rate definitions imply.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_baudrate_gen;

  localparam int DIV0 = 16;
  localparam int DIV1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic ce  = 1'b1;
  logic rateclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and scoreboard.
  int m_cnt   = 0;
  int m_selq  = 0;
  int m_rate  = 0;
  int q_rate[$];
  int q_cnt[$];
  int er, ec;

  baudrate_gen #(.DIV0(DIV0), .DIV1(DIV1)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .ce      (ce),
    .rateclk (rateclk)
  );

  always #1 clk = ~clk;

  // Advance one rising edge, update the model from the inputs that were
  // stable at that edge, push the expectation, then move a quarter-period
  // past the edge where the DUT outputs are sampled.
  task automatic step();
    int div;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_selq = 0; m_rate = 0;
    end else begin
      div = (m_selq != 0) ? DIV1 : DIV0;
      if (int'(sel) != m_selq) begin
        m_cnt = 0; m_rate = 0;
      end else if (!ce) begin
        m_rate = 0;
      end else if (m_cnt == div - 1) begin
        m_cnt = 0; m_rate = 1;
      end else begin
        m_cnt = m_cnt + 1; m_rate = 0;
      end
      m_selq = int'(sel);
    end
    q_rate.push_back(m_rate);
    q_cnt.push_back(m_cnt);
    #0.5;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_selq = 0; m_rate = 0;
  endtask

  task automatic test_reset();
    #0.5;
    n_checks++;
    if (rateclk !== 1'b0 || dut.cnt !== '0 || dut.sel_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state rateclk=%b cnt=%0d sel_q=%b expected 0/0/0", rateclk, dut.cnt, dut.sel_q);
    end
    // Reset must dominate clock edges even with sel=1 and ce=1.
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec || dut.sel_q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold edge=%0d rateclk=%b cnt=%0d sel_q=%b expected %0d/%0d/0", i, rateclk, dut.cnt, dut.sel_q, er, ec);
      end
    end
    sel = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_rate();
    for (int i = 1; i <= 48; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec) begin
        n_fail++;
        $display("FAIL basic_model edge=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
      n_checks++;
      if (rateclk !== ((i % DIV0) == 0)) begin
        n_fail++;
        $display("FAIL basic_tick_pos edge=%0d rateclk=%b expected %b", i, rateclk, (i % DIV0) == 0);
      end
    end
  endtask

  task automatic test_rate_switch();
    for (int i = 0; i < 5; i++) begin
      step();
      void'(q_rate.pop_front()); void'(q_cnt.pop_front());
    end
    n_checks++;
    if (dut.cnt !== 5) begin
      n_fail++;
      $display("FAIL switch_precnt cnt=%0d expected 5", dut.cnt);
    end
    sel = 1'b1;
    step();
    er = q_rate.pop_front(); ec = q_cnt.pop_front();
    n_checks++;
    if (rateclk !== 1'b0 || dut.cnt !== 0 || rateclk !== er[0] || dut.cnt !== ec) begin
      n_fail++;
      $display("FAIL switch_restart rateclk=%b cnt=%0d expected 0/0", rateclk, dut.cnt);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec || rateclk !== ((i % DIV1) == 0)) begin
        n_fail++;
        $display("FAIL switch_tick edge=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
    end
  endtask

  task automatic test_enable_gating();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      void'(q_rate.pop_front()); void'(q_cnt.pop_front());
    end
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== 1'b0 || dut.cnt !== 7 || dut.cnt !== ec) begin
        n_fail++;
        $display("FAIL gate_hold cycle=%0d rateclk=%b cnt=%0d expected 0/7", i, rateclk, dut.cnt);
      end
    end
    ce = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec || rateclk !== (i == 9)) begin
        n_fail++;
        $display("FAIL gate_resume edge=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      void'(q_rate.pop_front()); void'(q_cnt.pop_front());
    end
    n_checks++;
    if (dut.cnt !== 12) begin
      n_fail++;
      $display("FAIL areset_precnt cnt=%0d expected 12", dut.cnt);
    end
    #0.2 rst = 1'b1;
    model_clear();
    #0.1;
    n_checks++;
    if (rateclk !== 1'b0 || dut.cnt !== 0) begin
      n_fail++;
      $display("FAIL areset_immediate rateclk=%b cnt=%0d expected 0/0", rateclk, dut.cnt);
    end
    step();
    void'(q_rate.pop_front()); void'(q_cnt.pop_front());
    rst = 1'b0;
    for (int i = 1; i <= DIV0; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec || rateclk !== (i == DIV0)) begin
        n_fail++;
        $display("FAIL areset_restart edge=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
    end
    // rateclk is high now; an asynchronous reset must clear it before the next edge.
    #0.2 rst = 1'b1;
    model_clear();
    #0.1;
    n_checks++;
    if (rateclk !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clears_tick rateclk=%b expected 0", rateclk);
    end
  endtask

  task automatic test_reset_sel1();
    sel = 1'b1;
    ce  = 1'b1;
    step();
    void'(q_rate.pop_front()); void'(q_cnt.pop_front());
    rst = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec ||
          rateclk !== (i >= 5 && ((i - 1) % DIV1) == 0)) begin
        n_fail++;
        $display("FAIL rst_sel1 edge=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
    end
  endtask

  task automatic test_random();
    logic prev_r   = 1'b0;
    logic last_sel = sel;
    bit   clean    = 1'b0;
    bit   have_prev = 1'b0;
    int   gap      = 0;
    int   gaps_checked = 0;
    for (int i = 0; i < 2000; i++) begin
      ce = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) sel = ~sel;
      gap++;
      if (!ce || sel != last_sel) clean = 1'b0;
      last_sel = sel;
      step();
      er = q_rate.pop_front(); ec = q_cnt.pop_front();
      n_checks++;
      if (rateclk !== er[0] || dut.cnt !== ec) begin
        n_fail++;
        $display("FAIL rand_model cycle=%0d rateclk=%b cnt=%0d expected %0d/%0d", i, rateclk, dut.cnt, er, ec);
      end
      n_checks++;
      if (rateclk === 1'b1 && prev_r === 1'b1) begin
        n_fail++;
        $display("FAIL rand_width cycle=%0d rateclk high on 2 consecutive cycles, expected single-cycle", i);
      end
      if (rateclk === 1'b1) begin
        if (clean && have_prev) begin
          gaps_checked++;
          n_checks++;
          if (gap != (sel ? DIV1 : DIV0)) begin
            n_fail++;
            $display("FAIL rand_gap cycle=%0d gap=%0d expected %0d", i, gap, sel ? DIV1 : DIV0);
          end
        end
        gap = 0; clean = 1'b1; have_prev = 1'b1;
      end
      prev_r = rateclk;
    end
    n_checks++;
    if (gaps_checked == 0) begin
      n_fail++;
      $display("FAIL rand_gap_coverage gaps_checked=0 expected >0");
    end
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_rate_switch();
    test_enable_gating();
    test_async_reset();
    test_reset_sel1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baudrate_gen.md
BAUDRATE_GEN -- requirements
Module: baudrate_gen

Interface
REQ-001 Parameter DIV0, default 16: divide ratio used when sel=0; integer, 2 or greater.
REQ-002 Parameter DIV1, default 4: divide ratio used when sel=1; integer, 2 or greater.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port sel, input, 1 bit: rate select (0 selects DIV0, 1 selects DIV1).
REQ-006 Port ce, input, 1 bit: count enable.
REQ-007 Port rateclk, output, 1 bit: registered baud tick, one clk cycle wide.

Function
REQ-008 State SHALL be:
- cnt: unsigned, width clog2(max(DIV0,DIV1)).
- sel_q: 1-bit registered copy of sel.
- rateclk register.
REQ-009 DIV is the active ratio: DIV0 when sel_q=0, DIV1 when sel_q=1.
REQ-010 sel_q SHALL sample sel on every rising edge, regardless of ce.
REQ-011 Rate change: if sel differs from sel_q at an edge, cnt<=0 and rateclk<=0 at that edge, regardless of ce. The new rate's period then starts from zero.
REQ-012 Hold: else, if ce=0, cnt holds its value and rateclk<=0.
REQ-013 Terminal count: else, if ce=1 and cnt==DIV-1, cnt<=0 and rateclk<=1.
REQ-014 Count: else, with ce=1, cnt<=cnt+1 and rateclk<=0.
REQ-015 With ce held at 1 and sel stable, rateclk SHALL pulse high for exactly 1 cycle every DIV cycles (DIV-1 low cycles between pulses).
REQ-016 Latency: first pulse appears after the DIV-th rising edge counted from when counting starts at cnt=0 (reset release or rate change).
REQ-017 ce low mid-period freezes the count. On re-enable, the remaining count continues with no restart; the high time of a pulse never exceeds 1 cycle.
REQ-018 rateclk SHALL never be high for 2 consecutive cycles.
REQ-019 cnt SHALL never exceed max(DIV0,DIV1)-1. Terminal-count wrap SHALL be to 0, never via overflow.
REQ-020 There SHALL be no combinational path from any input to rateclk.

Reset
REQ-021 While rst=1: cnt=0, sel_q=0, rateclk=0, asynchronously and independent of clk.
REQ-022 Reset asserted mid-period SHALL discard the partial count. After release, counting restarts per REQ-016.
REQ-023 If sel=1 when reset is released, the first edge SHALL act as a rate change per REQ-011 (sel_q loads 1, cnt stays 0). The first DIV1 pulse then follows DIV1 edges later.

Verification
REQ-024 Basic rate:
- Stimulus: rst=1, then release with ce=1, sel=0 (DIV0=16), clk period 2 ns.
- Response: rateclk high after edges 16, 32, 48, each for 1 cycle; low otherwise.
REQ-025 Rate switch:
- Stimulus: as REQ-024, then sel 0->1 mid-period (cnt=5).
- Response: next edge cnt=0, rateclk=0; pulses 4 edges later, then every 4 cycles.
REQ-026 Enable gating:
- Stimulus: ce=0 for 10 cycles at cnt=7.
- Response: rateclk stays 0 and cnt stays 7 throughout; after ce=1, pulse after 9 further edges.
REQ-027 Async reset:
- Stimulus: assert rst between clock edges at cnt=12.
- Response: rateclk=0 and cnt=0 immediately; first pulse 16 edges after release.
REQ-028 Pulse width and spacing:
- Stimulus: random sel/ce toggling over 2000 cycles.
- Response: rateclk never high on 2 consecutive cycles; with ce=1 and sel stable, gaps between pulses are exactly DIV0 or DIV1.
REQ-029 Reset with sel=1:
- Stimulus: release rst with sel=1, ce=1.
- Response: first pulse after edge 5, then every 4 cycles.
